// File: rtl/mult_pkg.sv
// Shared definitions for the iterative digit-serial multiplier:
// the controller state encoding and the digit-count helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide multiplier slices needed to cover WIDTH bits.
    function automatic int num_digits(input int width, input int digit);
        return (width + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational WIDTH x DIGIT partial-product unit: multiplies the latched
// multiplicand by one multiplier digit. The result is never truncated.
module mult_digit #(
    parameter int WIDTH = 18,
    parameter int DIGIT = 6
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [DIGIT-1:0]       d,
    output logic [WIDTH+DIGIT-1:0] pp
);

    // Full-width product of the multiplicand and the current digit.
    always_comb begin
        pp = (WIDTH + DIGIT)'(a) * (WIDTH + DIGIT)'(d);
    end

endmodule

// File: rtl/mult_iter.sv
// Iterative multiplier retiring DIGIT multiplier bits per clock.
// A product takes N = ceil(WIDTH/DIGIT) cycles after the capture edge.
// Optional feature: define MULT_ITER_SIGNED_EN to add the is_signed port,
// which selects two's-complement operands (sign/magnitude internally, so
// latency is the same in both builds).
module mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DIGIT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef MULT_ITER_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0]    LAST  = CW'(N - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P = PW'(1);

    // Reject parameter combinations the datapath was not sized for.
    generate
        if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_params
            $error("mult_iter: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
        end
    endgenerate

    state_t                  state;
    logic [WIDTH-1:0]        a_reg;
    logic [WIDTH-1:0]        b_reg;
    logic [PW-1:0]           acc;
    logic [CW-1:0]           cnt;
    logic                    neg;

    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;
    logic                    neg_in;
    logic [DIGIT-1:0]        digit;
    logic [WIDTH+DIGIT-1:0]  pp;
    logic [PW-1:0]           term;
    logic [PW-1:0]           sum;
    logic [PW-1:0]           result;

`ifdef MULT_ITER_SIGNED_EN
    // Turn signed operands into magnitudes and remember the product sign.
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
        if (is_signed) begin
            if (A[WIDTH-1]) a_mag = ~A + ONE_W;
            if (B[WIDTH-1]) b_mag = ~B + ONE_W;
            neg_in = A[WIDTH-1] ^ B[WIDTH-1];
        end
    end
`else
    // Unsigned-only build: operands pass straight through.
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
    end
`endif

    // The multiplier register is shifted down each cycle, so the low slice is
    // always the current digit; zeros shift in to pad the final digit.
    always_comb begin
        digit = b_reg[DIGIT-1:0];
    end

    mult_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_digit (
        .a  (a_reg),
        .d  (digit),
        .pp (pp)
    );

    // Align the partial product to its digit position, accumulate, and
    // apply the recorded sign so the last edge can write the final product.
    always_comb begin
        term   = PW'(pp) << (int'(cnt) * DIGIT);
        sum    = acc + term;
        result = neg ? (~sum + ONE_P) : sum;
    end

    // Controller and datapath registers: capture, iterate, hold, abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        neg   <= neg_in;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        acc   <= sum;
                        P     <= result;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        acc   <= sum;
                        cnt   <= cnt + CW'(1);
                        b_reg <= b_reg >> DIGIT;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// Bench for mult_iter: a default 18x18 (digit 6) instance for the directed
// vectors and corner sequences, and a 20x20 (digit 7) instance for the
// long random run. Signed vectors are added when MULT_ITER_SIGNED_EN is set.
module tb_mult_iter;

    localparam int W0 = 18;
    localparam int W1 = 20;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic            start0;
    logic [W0-1:0]   a0, b0;
    logic            busy0, done0;
    logic [2*W0-1:0] p0;

    logic            start1;
    logic [W1-1:0]   a1, b1;
    logic            busy1, done1;
    logic [2*W1-1:0] p1;

`ifdef MULT_ITER_SIGNED_EN
    logic sgn0;
    logic sgn1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_iter #(.WIDTH(W0), .DIGIT(6)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .A         (a0),
        .B         (b0),
`ifdef MULT_ITER_SIGNED_EN
        .is_signed (sgn0),
`endif
        .busy      (busy0),
        .done      (done0),
        .P         (p0)
    );

    mult_iter #(.WIDTH(W1), .DIGIT(7)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .A         (a1),
        .B         (b1),
`ifdef MULT_ITER_SIGNED_EN
        .is_signed (sgn1),
`endif
        .busy      (busy1),
        .done      (done1),
        .P         (p1)
    );

    typedef struct {
        logic [W0-1:0]   a;
        logic [W0-1:0]   b;
        logic            sgn;
        logic [2*W0-1:0] p;
    } vec_t;

    vec_t vecs[$];

    // Reference product: plain integer arithmetic, truncated to 2*W0 bits.
    function automatic logic [2*W0-1:0] model0(input logic [W0-1:0] a,
                                               input logic [W0-1:0] b,
                                               input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({46'd0, a});
            sb = longint'({46'd0, b});
        end
        return (2*W0)'(sa * sb);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full operation on the 18-bit instance, including hold and release.
    task automatic applyStimulus(input logic [W0-1:0] a, input logic [W0-1:0] b,
                                 input logic sgn, input logic [2*W0-1:0] expected,
                                 input string name);
        int lat;
        @(negedge clk);
        a0 = a;
        b0 = b;
`ifdef MULT_ITER_SIGNED_EN
        sgn0 = sgn;
`endif
        start0 = 1'b1;
        @(posedge clk);
        #1;
        a0 = W0'($urandom);
        b0 = W0'($urandom);
`ifdef MULT_ITER_SIGNED_EN
        sgn0 = ~sgn;
`endif
        checkOutput({name, " busy after capture"}, 64'(busy0), 64'd1);
        lat = 0;
        while (!done0 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, 64'(lat), 64'(LAT));
        checkOutput({name, " product"}, 64'(p0), 64'(expected));
        checkOutput({name, " busy at done"}, 64'(busy0), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({name, " done held"}, 64'(done0), 64'd1);
        checkOutput({name, " product held"}, 64'(p0), 64'(expected));
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, " done released"}, 64'(done0), 64'd0);
        checkOutput({name, " product kept"}, 64'(p0), 64'(expected));
        if (sgn) begin end
    endtask

    // One operation on the 20-bit instance against an unsigned model.
    task automatic applyWideStimulus(input logic [W1-1:0] a, input logic [W1-1:0] b);
        int lat;
        logic [2*W1-1:0] expected;
        expected = (2*W1)'(64'(a) * 64'(b));
        @(negedge clk);
        a1 = a;
        b1 = b;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        a1 = W1'($urandom);
        b1 = W1'($urandom);
        lat = 0;
        while (!done1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("wide latency", 64'(lat), 64'(LAT));
        checkOutput("wide product", 64'(p1), 64'(expected));
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        logic [2*W0-1:0] prior;
        int lat;
        logic [W0-1:0] ra, rb;
        logic rs;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        a0 = '0;
        b0 = '0;
        a1 = '0;
        b1 = '0;
`ifdef MULT_ITER_SIGNED_EN
        sgn0 = 1'b0;
        sgn1 = 1'b0;
`endif
        #1;
        checkOutput("reset busy", 64'(busy0), 64'd0);
        checkOutput("reset done", 64'(done0), 64'd0);
        checkOutput("reset product", 64'(p0), 64'd0);
        checkOutput("reset wide product", 64'(p1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{a: 18'd3,      b: 18'd5,      sgn: 1'b0, p: 36'd15});
        vecs.push_back('{a: 18'd262143, b: 18'd262143, sgn: 1'b0, p: 36'd68718952449});
        vecs.push_back('{a: 18'd0,      b: 18'd12345,  sgn: 1'b0, p: 36'd0});
        vecs.push_back('{a: 18'd1,      b: 18'd262143, sgn: 1'b0, p: 36'd262143});
        vecs.push_back('{a: 18'd131072, b: 18'd2,      sgn: 1'b0, p: 36'd262144});
        vecs.push_back('{a: 18'd1000,   b: 18'd999,    sgn: 1'b0, p: 36'd999000});
        vecs.push_back('{a: 18'd262141, b: 18'd5,      sgn: 1'b0, p: 36'd1310705});
`ifdef MULT_ITER_SIGNED_EN
        vecs.push_back('{a: 18'h20000,  b: 18'h20000,  sgn: 1'b1, p: 36'd17179869184});
        vecs.push_back('{a: 18'h3FFFD,  b: 18'd5,      sgn: 1'b1, p: 36'hFFFFFFFF1});
        vecs.push_back('{a: 18'h3FFFF,  b: 18'h3FFFF,  sgn: 1'b1, p: 36'd1});
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Abort after one BUSY cycle: nothing completes, P keeps its old value.
        prior = p0;
        @(negedge clk);
        a0 = 18'd7;
        b0 = 18'd9;
        start0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort done", 64'(done0), 64'd0);
            checkOutput("abort busy", 64'(busy0), 64'd0);
            checkOutput("abort product", 64'(p0), 64'(prior));
        end

        // Reset in the middle of BUSY with start held: restart after release.
        @(negedge clk);
        a0 = 18'd1234;
        b0 = 18'd4321;
        start0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 64'(busy0), 64'd0);
        checkOutput("midreset done", 64'(done0), 64'd0);
        checkOutput("midreset product", 64'(p0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restart busy", 64'(busy0), 64'd1);
        lat = 0;
        while (!done0 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("restart latency", 64'(lat), 64'(LAT));
        checkOutput("restart product", 64'(p0), 64'(model0(18'd1234, 18'd4321, 1'b0)));
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);

        // Random operands on the default instance against the model.
        for (int k = 0; k < 40; k++) begin
            ra = W0'($urandom);
            rb = W0'($urandom);
`ifdef MULT_ITER_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, rs, model0(ra, rb, rs), "rand18");
        end

        // Long random run on the 20-bit, 7-bit-digit instance.
        for (int k = 0; k < 1000; k++) begin
            applyWideStimulus(W1'($urandom), W1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter WIDTH, default 18, operand width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 6, multiplier bits retired per cycle; legal range 1..WIDTH; WIDTH need not be a multiple of DIGIT.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  level-sensitive request; held high until done is seen, then dropped.
REQ-006 Port A  input  WIDTH  multiplicand, sampled only at the capture edge.
REQ-007 Port B  input  WIDTH  multiplier, sampled only at the capture edge.
REQ-008 Port is_signed  input  1  two's-complement mode select, sampled at capture; present only when MULT_ITER_SIGNED_EN is defined.
REQ-009 Port busy  output  1  high while the block is in BUSY.
REQ-010 Port done  output  1  high while the block is in DONE; P is valid whenever done is high.
REQ-011 Port P  output  2*WIDTH  product.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 Define N = ceil(WIDTH/DIGIT); for defaults N = 3.
REQ-014 IDLE with start=1 at an edge (the capture edge): latch A and B, clear the accumulator, set the digit counter to 0, and go to BUSY.
REQ-015 In BUSY, each edge SHALL add A_latched * B_latched[digit i] << (i*DIGIT) to the accumulator and increment i.
REQ-016 Digit N-1 SHALL be zero-extended above bit WIDTH-1.
REQ-017 On the edge that retires digit N-1: P <= final product, done <= 1, busy <= 0, state goes to DONE.
REQ-018 done SHALL first be high exactly N edges after the capture edge.
REQ-019 DONE SHALL hold P and done stable while start=1.
REQ-020 DONE with start=0 at an edge: go to IDLE and set done <= 0; P retains its value.
REQ-021 A new capture SHALL require an IDLE cycle, so done never stays high across two operations.
REQ-022 start=0 at any BUSY edge SHALL abort the operation: go to IDLE; done stays 0; P is unchanged; the partial result is discarded.
REQ-023 A and B changes after the capture edge SHALL have no effect on the operation in progress.
REQ-024 Unsigned mode: P = A*B exactly, with no truncation; max case (2^W-1)^2 fits in 2W bits.
REQ-025 busy SHALL be 1 exactly during the N BUSY cycles.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, P 0, accumulator 0, counter 0.
REQ-027 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; no done pulse follows after release.
REQ-028 After rst_n rises with start already high, capture SHALL occur at the first edge after release.

Configuration
REQ-029 Macro MULT_ITER_SIGNED_EN, when defined, SHALL add the is_signed port.
REQ-030 With is_signed=1 at capture, operands SHALL be converted to magnitudes, the sign of the result recorded, and the result negated on the final edge with no extra cycle.
REQ-031 In signed mode, -2^(W-1) * -2^(W-1) = +2^(2W-2) SHALL be exact.
REQ-032 Without MULT_ITER_SIGNED_EN, the port SHALL be absent, behaviour SHALL be unsigned only, and latency SHALL be identical in both builds.

Structure
REQ-033 Package mult_pkg SHALL hold the state enum typedef (IDLE, BUSY, DONE) and a constant function computing N from WIDTH and DIGIT.
REQ-034 Sub-module mult_digit SHALL be the combinational WIDTH x DIGIT partial-product unit; the iteration FSM and accumulator SHALL live in mult_iter.
REQ-035 Elaboration SHALL fail on an illegal WIDTH or DIGIT.

Verification (WIDTH=18, DIGIT=6 unless stated)
REQ-036 A=3, B=5, start held -> done high 3 edges after capture, P=15; start low -> done low next edge.
REQ-037 A=B=262143 -> P=68718952449 (0xFFFF80001).
REQ-038 start dropped after 1 BUSY cycle with A=7, B=9 -> back to IDLE, done never rises, P keeps its prior value.
REQ-039 rst_n pulsed low mid-BUSY -> outputs 0 asynchronously; with start held, a fresh capture occurs after release and yields the correct P.
REQ-040 Signed build, is_signed=1: A=-131072, B=-131072 -> P=17179869184; A=-3, B=5 -> P=-15 (2's complement, 36 bits).
REQ-041 WIDTH=20, DIGIT=7 (N=3): random A and B, 1000 operations, compared against a reference model; latency is always 3.
